// File: rtl/debug_probe_pkg.sv
// Shared display types for the debug probe selector: segment type, blank
// pattern and the active-low hex glyph table with its lookup function.
package debug_probe_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Index is the nibble value; bit0=a .. bit6=g, active-low.
  localparam seg_t HEX_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic seg_t hex_glyph(input logic [3:0] nib);
    return HEX_GLYPH[nib];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw active-low push button to single-cycle press event: 2-flop
// synchroniser, stability counter, accepted level and rising-edge pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press_evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             pressed;

  // The chain carries the pressed level, so "cleared" also means "released".
  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= 2'b00;
      cnt       <= '0;
      pressed   <= 1'b0;
      press_evt <= 1'b0;
    end else begin
      sync      <= {sync[0], ~btn_n};
      press_evt <= 1'b0;
      if (sync[1] == pressed) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        pressed   <= sync[1];
        cnt       <= '0;
        press_evt <= sync[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/debug_probe_display.sv
// Probe channel selector driving DIGITS seven-segment displays with button
// stepping, auto-scroll and freeze. Define DEBUG_PROBE_BLANK_EN to blank
// leading-zero digits.
module debug_probe_display
  import debug_probe_pkg::*;
#(
  parameter int NUM_CH       = 14,
  parameter int DATA_W       = 32,
  parameter int DIGITS       = DATA_W / 4,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int AUTO_PERIOD  = 50000000,
  parameter int SEL_W        = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] probe_flat,
  input  logic                     btn_next_n,
  input  logic                     btn_prev_n,
  input  logic                     auto_en,
  input  logic                     freeze,
  output logic [DIGITS*7-1:0]      seg_flat,
  output logic [SEL_W-1:0]         sel,
  output logic                     step_pulse
);

  localparam int AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  logic              next_evt;
  logic              prev_evt;
  logic [AUTO_W-1:0] auto_timer;
  logic              auto_tick;
  logic [SEL_W-1:0]  sel_nxt;
  logic [SEL_W-1:0]  sel_inc;
  logic [SEL_W-1:0]  sel_dec;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] hold;
  logic [DIGITS*7-1:0] seg_nxt;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_next (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn_next_n),
    .press_evt (next_evt)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_prev (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn_prev_n),
    .press_evt (prev_evt)
  );

  assign auto_tick = auto_en && (auto_timer == AUTO_W'(AUTO_PERIOD - 1));

  // Manual events restart the spacing so auto-scroll never lands right after a press.
  always_ff @(posedge clk) begin
    if (rst || !auto_en || next_evt || prev_evt || auto_tick) begin
      auto_timer <= '0;
    end else begin
      auto_timer <= auto_timer + AUTO_W'(1);
    end
  end

  assign sel_inc = (sel == SEL_W'(NUM_CH - 1)) ? '0 : sel + SEL_W'(1);
  assign sel_dec = (sel == '0) ? SEL_W'(NUM_CH - 1) : sel - SEL_W'(1);

  always_comb begin
    sel_nxt = sel;
    if (next_evt && prev_evt) begin
      sel_nxt = sel;
    end else if (next_evt) begin
      sel_nxt = sel_inc;
    end else if (prev_evt) begin
      sel_nxt = sel_dec;
    end else if (auto_tick) begin
      sel_nxt = sel_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel        <= '0;
      step_pulse <= 1'b0;
    end else begin
      sel        <= sel_nxt;
      step_pulse <= (sel_nxt != sel);
    end
  end

  // Any index without a matching channel falls back to channel 0.
  always_comb begin
    word = probe_flat[DATA_W-1:0];
    for (int i = 1; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) word = probe_flat[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
    end else if (!freeze) begin
      hold <= word;
    end
  end

  always_comb begin
`ifdef DEBUG_PROBE_BLANK_EN
    logic leading;
    leading = 1'b1;
`endif
    seg_nxt = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      seg_nxt[d*7 +: 7] = hex_glyph(hold[d*4 +: 4]);
`ifdef DEBUG_PROBE_BLANK_EN
      if (hold[d*4 +: 4] != 4'h0 || d == 0) leading = 1'b0;
      if (leading) seg_nxt[d*7 +: 7] = SEG_BLANK;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_flat <= {DIGITS{HEX_GLYPH[0]}};
    end else begin
      seg_flat <= seg_nxt;
    end
  end

endmodule

// File: doc/debug_probe_display.md
Name: debug_probe_display

Overview:
- Parametrised successor to the board-level debug selector.
- Chooses one of NUM_CH probe words from the datapath (PC, ALU result, control bits, ...) and renders it on DIGITS seven-segment displays.
- Supports debounced next/prev stepping, an auto-scroll mode and a freeze snapshot.
- Sits at the FPGA top level between the CPU probe bus and the HEX outputs, fully synchronous to the system clock.

Parameters:
- NUM_CH, 14: number of probe channels, 2..64.
- DATA_W, 32: bits per probe channel, a multiple of 4.
- DIGITS, DATA_W/4: number of hex digits driven.
- DEBOUNCE_CYC, 50000: cycles a synchronised button level must be stable before it is accepted, at least 2.
- AUTO_PERIOD, 50000000: cycles between auto-scroll steps, at least 1.
- SEL_W, $clog2(NUM_CH): width of the channel index.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- probe_flat  in  NUM_CH*DATA_W  probe channels; channel i occupies bits [i*DATA_W +: DATA_W].
- btn_next_n  in  1  raw push button, active-low, asynchronous: step forward.
- btn_prev_n  in  1  raw push button, active-low, asynchronous: step back.
- auto_en  in  1  level: enable auto-scroll.
- freeze  in  1  level: hold the displayed value.
- seg_flat  out  DIGITS*7  segments, active-low; digit d occupies bits [d*7 +: 7]; digit 0 is the least-significant nibble; bit0=a .. bit6=g.
- sel  out  SEL_W  current channel index.
- step_pulse  out  1  single-cycle pulse whenever sel changes.

Behaviour:
- One clock domain, `clk`; `rst` is synchronous and active-high. Every register, including the sync chain, debounce counters and auto timer, clears on the rst cycle.
- Reset values:
  - sel=0, step_pulse=0, auto timer=0.
  - Debounced button state = released.
  - Hold register = 0.
  - seg_flat = all digits showing "0" (7'b1000000 each).
- Button path, applied to each button:
  - 2-flop synchroniser, then a debounce counter.
  - The counter resets whenever the synchronised level differs from the accepted level.
  - When the counter reaches DEBOUNCE_CYC-1, the accepted level takes the synchronised level.
  - An accepted released-to-pressed transition produces a one-cycle event. Release produces nothing.
- Selection update, in the cycle after an event. Priority, highest first:
  1. Next and prev events in the same cycle: no change, no step_pulse.
  2. Next event: sel = (sel==NUM_CH-1) ? 0 : sel+1.
  3. Prev event: sel = (sel==0) ? NUM_CH-1 : sel-1.
  4. Auto tick: same arithmetic as next.
- Auto tick:
  - While auto_en=1, the timer counts 0..AUTO_PERIOD-1, and the tick fires on the terminal count.
  - Any manual event clears the timer.
  - auto_en=0 holds the timer at 0.
  - An auto tick coinciding with a manual event is discarded.
- step_pulse is registered and asserted in the same cycle that sel takes its new value.
- Display word:
  - freeze=0: the hold register loads the selected channel every cycle.
  - freeze=1: the hold register keeps its value. sel still steps, but the display does not change until freeze drops.
  - On the rising edge of freeze, the value captured is the one loaded in that same cycle.
- Latency: seg_flat is registered from the hold register. A probe change appears on seg_flat 2 cycles later; a new sel appears 2 cycles after sel updates.
- Out-of-range sel is unreachable. It must still map to channel 0 if NUM_CH is not a power of two.
- Hex glyphs, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110

Optional Feature:
- Macro: DEBUG_PROBE_BLANK_EN.
- Defined: leading-zero digits are blanked (7'b1111111). Blanking runs from the most significant digit down to, but not including, the first non-zero nibble. Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: all DIGITS are always lit.

Decomposition:
- Package `debug_probe_pkg`:
  - SEG_BLANK constant.
  - 16-entry hex glyph constant array.
  - `seg_t` typedef (logic [6:0]).
- Sub-module `btn_debounce`: synchroniser, debounce counter and press-event pulse. Instantiated twice.
- The glyph lookup is a package function, not a separate module.

Test Plan:
All scenarios use NUM_CH=14, DATA_W=32, DEBOUNCE_CYC=4, AUTO_PERIOD=10. Channel i is driven with 32'h1000_0000+i.
- Reset, then 14 clean next presses: sel steps 1..13 then wraps to 0, with exactly 14 step_pulses. At sel=3, seg_flat digit0=0110000 ("3") and digit7=1111001 ("1").
- Prev press at sel=0 gives sel=13. A 2-cycle low glitch on btn_next_n gives no step. Next and prev accepted in the same cycle give no change and no step_pulse.
- auto_en=1 held for 35 cycles gives 3 steps, spaced 10 cycles apart. A manual next at cycle 15 restarts the spacing from that event.
- freeze=1 at sel=5 followed by 2 next presses: sel=7, seg_flat still shows 1000_0005. Dropping freeze shows 1000_0007 two cycles later.
- rst asserted mid-debounce and mid-auto-count: next cycle sel=0, no step_pulse, seg_flat all "0". The pending press is not counted.
- With DEBUG_PROBE_BLANK_EN, probe 32'h0000_00A3: digits 7..2 are 1111111, digit1=0001000, digit0=0110000. Probe value 0 shows only digit0=1000000.
